// File: rtl/fetch_sel_dreg.sv
// fetch_sel_dreg -- PC select and the F/D pipeline registers around the
// Y86-64 fetch stage.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge) and synchronous active-low reset
//   F_stall_i               hold F_predPC
//   D_stall_i, D_bubble_i   hold D / load a NOP bubble into D (stall wins)
//   M_icode_i, M_Cnd_i,     mispredicted-jump recovery inputs
//   M_valA_i
//   W_icode_i, W_valM_i     ret recovery inputs
//   f_*_i                   fetch-stage outputs captured into D and F
//   f_pc_o                  selected fetch PC (combinational)
//   F_predPC_o              F register contents
//   D_*_o                   D register contents
//   perf_*_cnt_o            saturating performance counters
//
// Optional feature macro: FETCH_PERF_EN. When it is defined, the three
// counters are implemented; otherwise they are tied to zero.

module fetch_sel_dreg #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [3:0]  NOP_ICODE = 4'h1,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              F_stall_i,
    input  logic              D_stall_i,
    input  logic              D_bubble_i,
    input  logic [3:0]        M_icode_i,
    input  logic              M_Cnd_i,
    input  logic [63:0]       M_valA_i,
    input  logic [3:0]        W_icode_i,
    input  logic [63:0]       W_valM_i,
    input  logic [63:0]       f_predPC_i,
    input  logic [3:0]        f_icode_i,
    input  logic [3:0]        f_ifun_i,
    input  logic [3:0]        f_rA_i,
    input  logic [3:0]        f_rB_i,
    input  logic [63:0]       f_valC_i,
    input  logic [63:0]       f_valP_i,
    input  logic [2:0]        f_stat_i,
    output logic [63:0]       f_pc_o,
    output logic [63:0]       F_predPC_o,
    output logic [2:0]        D_stat_o,
    output logic [3:0]        D_icode_o,
    output logic [3:0]        D_ifun_o,
    output logic [3:0]        D_rA_o,
    output logic [3:0]        D_rB_o,
    output logic [63:0]       D_valC_o,
    output logic [63:0]       D_valP_o,
    output logic [PERF_W-1:0] perf_stall_cnt_o,
    output logic [PERF_W-1:0] perf_bubble_cnt_o,
    output logic [PERF_W-1:0] perf_mispred_cnt_o
);

    localparam logic [3:0] IJXX = 4'h7;
    localparam logic [3:0] IRET = 4'h9;
    localparam logic [2:0] SAOK = 3'd1;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } dreg_t;

    localparam dreg_t D_BUBBLE = '{
        stat:  SAOK,
        icode: NOP_ICODE,
        ifun:  4'h0,
        rA:    4'hF,
        rB:    4'hF,
        valC:  64'h0,
        valP:  64'h0
    };

    logic        mispred;
    logic        ret_sel;
    logic [63:0] F_predPC_d, F_predPC_q;
    dreg_t       D_d, D_q;

    // Mispredict recovery has priority over ret recovery.
    assign mispred = (M_icode_i == IJXX) && !M_Cnd_i;
    assign ret_sel = (W_icode_i == IRET);

    always_comb begin
        if (mispred) begin
            f_pc_o = M_valA_i;
        end else if (ret_sel) begin
            f_pc_o = W_valM_i;
        end else begin
            f_pc_o = F_predPC_q;
        end
    end

    // F register
    always_comb begin
        F_predPC_d = F_predPC_q;
        if (!F_stall_i) begin
            F_predPC_d = f_predPC_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            F_predPC_q <= RESET_PC;
        end else begin
            F_predPC_q <= F_predPC_d;
        end
    end

    // D register: stall holds even when a bubble is also requested.
    always_comb begin
        D_d = D_q;
        if (D_stall_i) begin
            D_d = D_q;
        end else if (D_bubble_i) begin
            D_d = D_BUBBLE;
        end else begin
            D_d.stat  = f_stat_i;
            D_d.icode = f_icode_i;
            D_d.ifun  = f_ifun_i;
            D_d.rA    = f_rA_i;
            D_d.rB    = f_rB_i;
            D_d.valC  = f_valC_i;
            D_d.valP  = f_valP_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            D_q <= D_BUBBLE;
        end else begin
            D_q <= D_d;
        end
    end

    assign F_predPC_o = F_predPC_q;
    assign D_stat_o   = D_q.stat;
    assign D_icode_o  = D_q.icode;
    assign D_ifun_o   = D_q.ifun;
    assign D_rA_o     = D_q.rA;
    assign D_rB_o     = D_q.rB;
    assign D_valC_o   = D_q.valC;
    assign D_valP_o   = D_q.valP;

`ifdef FETCH_PERF_EN
    localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] stall_cnt_d,   stall_cnt_q;
    logic [PERF_W-1:0] bubble_cnt_d,  bubble_cnt_q;
    logic [PERF_W-1:0] mispred_cnt_d, mispred_cnt_q;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (D_stall_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + ONE;
        end
        if (D_bubble_i && !D_stall_i && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + ONE;
        end
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q   <= '0;
            bubble_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign perf_stall_cnt_o   = stall_cnt_q;
    assign perf_bubble_cnt_o  = bubble_cnt_q;
    assign perf_mispred_cnt_o = mispred_cnt_q;
`else
    assign perf_stall_cnt_o   = '0;
    assign perf_bubble_cnt_o  = '0;
    assign perf_mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_sel_dreg.sv
// Testbench for fetch_sel_dreg: directed test-plan steps followed by
// randomized traffic, checked against a cycle-level reference model.
// Honours FETCH_PERF_EN (counters expected to be zero when undefined).

module tb_fetch_sel_dreg;

    localparam int unsigned PW = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    logic          clk = 1'b0;
    logic          rst_n, F_stall, D_stall, D_bubble, M_Cnd;
    logic [3:0]    M_icode, W_icode, f_icode, f_ifun, f_rA, f_rB;
    logic [63:0]   M_valA, W_valM, f_predPC, f_valC, f_valP;
    logic [2:0]    f_stat;
    logic [63:0]   f_pc, F_predPC, D_valC, D_valP;
    logic [2:0]    D_stat;
    logic [3:0]    D_icode, D_ifun, D_rA, D_rB;
    logic [PW-1:0] c_stall, c_bubble, c_mispred;

    int unsigned ncmp = 0;
    int unsigned nfail = 0;

    // Reference model state
    logic [63:0] mF;
    logic [2:0]  mStat;
    logic [3:0]  mIcode, mIfun, mRA, mRB;
    logic [63:0] mValC, mValP;
    int unsigned nStall, nBubble, nMispred;

    fetch_sel_dreg #(.RESET_PC(RST_PC), .NOP_ICODE(4'h1), .PERF_W(PW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .F_stall_i(F_stall), .D_stall_i(D_stall),
        .D_bubble_i(D_bubble), .M_icode_i(M_icode), .M_Cnd_i(M_Cnd),
        .M_valA_i(M_valA), .W_icode_i(W_icode), .W_valM_i(W_valM),
        .f_predPC_i(f_predPC), .f_icode_i(f_icode), .f_ifun_i(f_ifun),
        .f_rA_i(f_rA), .f_rB_i(f_rB), .f_valC_i(f_valC), .f_valP_i(f_valP),
        .f_stat_i(f_stat), .f_pc_o(f_pc), .F_predPC_o(F_predPC),
        .D_stat_o(D_stat), .D_icode_o(D_icode), .D_ifun_o(D_ifun),
        .D_rA_o(D_rA), .D_rB_o(D_rB), .D_valC_o(D_valC), .D_valP_o(D_valP),
        .perf_stall_cnt_o(c_stall), .perf_bubble_cnt_o(c_bubble),
        .perf_mispred_cnt_o(c_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_pc();
        if (M_icode == 4'h7 && M_Cnd == 1'b0) return M_valA;
        if (W_icode == 4'h9) return W_valM;
        return mF;
    endfunction

    function automatic logic [63:0] sat(input int unsigned n);
`ifdef FETCH_PERF_EN
        return (n > (2**PW - 1)) ? 64'(2**PW - 1) : 64'(n);
`else
        return (n == 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    task automatic model_bubble();
        mStat = 3'd1; mIcode = 4'h1; mIfun = 4'h0; mRA = 4'hF; mRB = 4'hF;
        mValC = 64'h0; mValP = 64'h0;
    endtask

    // Advance the model using the inputs present before the edge, then clock.
    task automatic tick();
        if (!rst_n) begin
            mF = RST_PC;
            model_bubble();
            nStall = 0; nBubble = 0; nMispred = 0;
        end else begin
            if (!F_stall) mF = f_predPC;
            if (M_icode == 4'h7 && !M_Cnd) nMispred++;
            if (D_stall) begin
                nStall++;
            end else if (D_bubble) begin
                nBubble++;
                model_bubble();
            end else begin
                mStat = f_stat; mIcode = f_icode; mIfun = f_ifun; mRA = f_rA;
                mRB = f_rB; mValC = f_valC; mValP = f_valP;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        chk("f_pc", f_pc, exp_pc());
        chk("F_predPC", F_predPC, mF);
        chk("D_stat", 64'(D_stat), 64'(mStat));
        chk("D_icode", 64'(D_icode), 64'(mIcode));
        chk("D_ifun", 64'(D_ifun), 64'(mIfun));
        chk("D_rA", 64'(D_rA), 64'(mRA));
        chk("D_rB", 64'(D_rB), 64'(mRB));
        chk("D_valC", D_valC, mValC);
        chk("D_valP", D_valP, mValP);
        chk("perf_stall", 64'(c_stall), sat(nStall));
        chk("perf_bubble", 64'(c_bubble), sat(nBubble));
        chk("perf_mispred", 64'(c_mispred), sat(nMispred));
    endtask

    task automatic quiet_inputs();
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 4'h0; M_Cnd = 1'b1; M_valA = 64'h0;
        W_icode = 4'h0; W_valM = 64'h0;
        f_predPC = 64'h0; f_icode = 4'h0; f_ifun = 4'h0; f_rA = 4'h0; f_rB = 4'h0;
        f_valC = 64'h0; f_valP = 64'h0; f_stat = 3'd1;
    endtask

    task automatic random_inputs();
        logic [2:0] sel;
        sel = 3'($urandom_range(0, 7));
        rst_n    = ($urandom_range(0, 39) != 0);
        F_stall  = ($urandom_range(0, 3) == 0);
        D_stall  = ($urandom_range(0, 3) == 0);
        D_bubble = ($urandom_range(0, 3) == 0);
        M_icode  = (sel < 3) ? 4'h7 : 4'($urandom);
        M_Cnd    = 1'($urandom);
        M_valA   = {$urandom, $urandom};
        W_icode  = (sel > 4) ? 4'h9 : 4'($urandom);
        W_valM   = {$urandom, $urandom};
        f_predPC = {$urandom, $urandom};
        f_icode  = 4'($urandom); f_ifun = 4'($urandom);
        f_rA     = 4'($urandom); f_rB   = 4'($urandom);
        f_valC   = {$urandom, $urandom};
        f_valP   = {$urandom, $urandom};
        f_stat   = 3'($urandom);
    endtask

    initial begin
        quiet_inputs();

        // 1. Reset held two cycles with a non-AOK fetch status
        rst_n = 0; f_stat = 3'd4;
        tick(); tick();
        check_all();
        chk("rst_F", F_predPC, RST_PC);
        chk("rst_D_icode", 64'(D_icode), 64'h1);
        chk("rst_D_rA", 64'(D_rA), 64'hF);
        chk("rst_D_stat", 64'(D_stat), 64'd1);

        // 2. Normal flow
        rst_n = 1; f_stat = 3'd1;
        f_predPC = 64'h0A; f_icode = 4'h3; f_valC = 64'h55;
        tick();
        check_all();
        chk("flow_F", F_predPC, 64'h0A);
        chk("flow_D_icode", 64'(D_icode), 64'h3);
        chk("flow_D_valC", D_valC, 64'h55);

        // 3. Mispredict beats ret
        M_icode = 4'h7; M_Cnd = 0; M_valA = 64'h20;
        #1 chk("mispred_pc", f_pc, 64'h20);
        W_icode = 4'h9; W_valM = 64'h40;
        #1 chk("mispred_over_ret", f_pc, 64'h20);
        tick();
        check_all();

        // 4. Ret, then fall back to F_predPC
        M_icode = 4'h6;
        #1 chk("ret_pc", f_pc, 64'h40);
        W_icode = 4'h0;
        #1 chk("pred_pc", f_pc, F_predPC);
        chk("pred_pc_model", f_pc, mF);

        // 5. Stall / bubble interplay
        M_icode = 4'h0; M_Cnd = 1;
        f_icode = 4'h5; f_predPC = 64'h100; f_valP = 64'h77;
        tick();
        check_all();
        F_stall = 1; D_stall = 1; f_icode = 4'hB; f_predPC = 64'h200;
        tick(); tick();
        check_all();
        chk("stall_D_icode", 64'(D_icode), 64'h5);
        chk("stall_F", F_predPC, 64'h100);
        F_stall = 0; D_bubble = 1;
        tick();
        check_all();
        chk("stall_bubble_D_icode", 64'(D_icode), 64'h5);
        D_stall = 0;
        tick();
        check_all();
        chk("bubble_D_icode", 64'(D_icode), 64'h1);
        chk("bubble_D_valP", D_valP, 64'h0);
        D_bubble = 0;

        // 6. Counter saturation over 20 stall cycles, then reset mid-stall
        D_stall = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check_all();
        end
`ifdef FETCH_PERF_EN
        chk("stall_sat", 64'(c_stall), 64'hF);
`endif
        rst_n = 0; F_stall = 1;
        tick();
        check_all();
        chk("rst_over_stall_icode", 64'(D_icode), 64'h1);
        chk("rst_cnt", 64'(c_stall), 64'h0);
        rst_n = 1; F_stall = 0; D_stall = 0;

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            random_inputs();
            #1 chk("rand_f_pc", f_pc, exp_pc());
            tick();
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_sel_dreg.md
Name: fetch_sel_dreg

Overview:
- PC-select logic and the F and D pipeline registers that surround the Y86-64 fetch stage.
- Chooses the fetch PC each cycle from one of three sources: the F_predPC register, a mispredicted-branch recovery, or a ret-return recovery.
- Drives the fetch PC_i input with that PC.
- Latches fetch outputs into the D register under stall/bubble control from the pipeline control unit.

Parameters:
- RESET_PC, 64'h0: F_predPC value after reset.
- NOP_ICODE, 4'h1: icode inserted on a D bubble.
- PERF_W, 32: width of the optional performance counters.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  synchronous active-low reset
- F_stall_i  in  1  hold F_predPC
- D_stall_i  in  1  hold D register
- D_bubble_i  in  1  load NOP bubble into D
- M_icode_i  in  4  icode in M stage
- M_Cnd_i  in  1  branch condition in M stage
- M_valA_i  in  64  fall-through PC of the jump in M
- W_icode_i  in  4  icode in W stage
- W_valM_i  in  64  return address read by ret
- f_predPC_i  in  64  predicted next PC from fetch
- f_icode_i, f_ifun_i, f_rA_i, f_rB_i  in  4 each  fetch fields
- f_valC_i, f_valP_i  in  64 each  fetch constants
- f_stat_i  in  3  fetch status
- f_pc_o  out  64  selected fetch PC, wired to fetch PC_i
- F_predPC_o  out  64  F register contents
- D_stat_o  out  3  D register status
- D_icode_o, D_ifun_o, D_rA_o, D_rB_o  out  4 each  D register fields
- D_valC_o, D_valP_o  out  64 each  D register constants
- perf_stall_cnt_o, perf_bubble_cnt_o, perf_mispred_cnt_o  out  PERF_W each  optional counters

Behaviour:
- PC select (combinational):
  - f_pc_o = M_valA_i if M_icode_i==IJXX and !M_Cnd_i.
  - else W_valM_i if W_icode_i==IRET.
  - else F_predPC_o.
  - The mispredict term has priority over the ret term.
- F register, on each rising edge:
  - !rst_n_i -> F_predPC <= RESET_PC.
  - else F_stall_i -> hold.
  - else F_predPC <= f_predPC_i.
- D register, on each rising edge, in priority order:
  1. !rst_n_i -> bubble state.
  2. D_stall_i -> hold all fields.
  3. D_bubble_i -> bubble state.
  4. else load the f_* inputs.
- D_stall_i and D_bubble_i asserted together: the stall wins.
- Bubble state: stat=SAOK (3'd1), icode=NOP_ICODE, ifun=0, rA=rB=4'hF, valC=0, valP=0.
- Reset values: the F and D outputs as above. Counters are 0.
- Latency:
  - f_pc_o is 0-cycle combinational.
  - D outputs reflect f_* one cycle after capture.
  - A mispredict or ret recovery takes effect in the same cycle M/W present it.
- Reset is synchronous. Asserting it mid-stall overrides the stall on the next edge.
- No arithmetic is performed. All 64-bit PCs pass through unmodified. Wrap-around is the fetch stage's concern.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: three PERF_W-bit counters, saturating at all-ones, cleared by reset. Each increments at most once per clock:
  - stall counter: counts cycles with D_stall_i=1.
  - bubble counter: counts cycles where a bubble is actually loaded, i.e. D_bubble_i=1 and D_stall_i=0.
  - mispredict counter: counts cycles where the mispredict select term is active.
- Undefined: no counter flops; the counter outputs are tied to 0. The ports remain present.

Test Plan:
1. Reset: hold rst_n_i=0 with f_stat_i=3'd4 for 2 cycles -> F_predPC_o=RESET_PC, D_icode_o=4'h1, D_rA_o=4'hF, D_stat_o=3'd1.
2. Normal flow: f_predPC_i=64'h0A, f_icode_i=4'h3, f_valC_i=64'h55 -> next cycle F_predPC_o=64'h0A, D_icode_o=4'h3, D_valC_o=64'h55.
3. Mispredict: M_icode_i=4'h7, M_Cnd_i=0, M_valA_i=64'h20 -> f_pc_o=64'h20 the same cycle. Also drive W_icode_i=4'h9, W_valM_i=64'h40 -> f_pc_o still 64'h20.
4. Ret: W_icode_i=4'h9, W_valM_i=64'h40, M_icode_i=4'h6 -> f_pc_o=64'h40. With W_icode_i=4'h0 -> f_pc_o=F_predPC_o.
5. Stall/bubble: load D_icode=4'h5. Then F_stall_i=D_stall_i=1 for 2 cycles -> D and F hold. Then D_stall_i=D_bubble_i=1 -> D holds. Then D_bubble_i alone -> D_icode_o=4'h1, D_valP_o=0.
6. FETCH_PERF_EN with PERF_W=4: apply 20 stall cycles -> perf_stall_cnt_o saturates at 4'hF. Reset -> all counters 0.
